// File: rtl/ysyx_24070017_ifu.sv
// ysyx_24070017_ifu -- instruction fetch unit.
// Owns the architectural PC. It fetches one instruction at a time over an
// AR/R valid-ready handshake and holds it in a one-entry output buffer until
// decode accepts it. On acceptance the PC is loaded from dnpc.
// Optional feature macro: YSYX_24070017_IFU_FAULT_EN. When it is defined,
// a non-OK mem_rresp raises out_fault and zeroes out_inst.
module ysyx_24070017_ifu #(
   parameter int                     WORD_LENGTH = 32,
   parameter logic [WORD_LENGTH-1:0] RESET_PC    = 32'h80000000
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [WORD_LENGTH-1:0] mem_araddr,
   output logic                   mem_arvalid,
   input  logic                   mem_arready,
   input  logic [WORD_LENGTH-1:0] mem_rdata,
   input  logic [1:0]             mem_rresp,
   input  logic                   mem_rvalid,
   output logic                   mem_rready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_inst,
   output logic [WORD_LENGTH-1:0] out_pc,
`ifdef YSYX_24070017_IFU_FAULT_EN
   output logic                   out_fault,
`endif
   input  logic [WORD_LENGTH-1:0] dnpc
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t                 state_reg, state_next;
   logic [WORD_LENGTH-1:0] pc_reg, pc_next;
   logic [31:0]            inst_reg, inst_next;
   logic [WORD_LENGTH-1:0] out_pc_reg, out_pc_next;

`ifdef YSYX_24070017_IFU_FAULT_EN
   logic                   fault_reg, fault_next;
`else
   // The response status has no consumer without the fault feature.
   logic                   unused_rresp;
   assign unused_rresp = ^mem_rresp;
`endif

   // State and buffer registers; reset aborts any fetch in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         pc_reg     <= RESET_PC;
         inst_reg   <= 32'h00000000;
         out_pc_reg <= '0;
`ifdef YSYX_24070017_IFU_FAULT_EN
         fault_reg  <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         inst_reg   <= inst_next;
         out_pc_reg <= out_pc_next;
`ifdef YSYX_24070017_IFU_FAULT_EN
         fault_reg  <= fault_next;
`endif
      end
   end

   // Next-state and buffer-update logic; one fetch outstanding at a time.
   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      inst_next   = inst_reg;
      out_pc_next = out_pc_reg;
`ifdef YSYX_24070017_IFU_FAULT_EN
      fault_next  = fault_reg;
`endif
      case (state_reg)
         IDLE: state_next = REQ;
         REQ: begin
            if (mem_arready) state_next = RESP;
         end
         RESP: begin
            // Read data is only looked at here; stray rvalid elsewhere is ignored.
            if (mem_rvalid) begin
               inst_next   = mem_rdata[31:0];
               out_pc_next = pc_reg;
`ifdef YSYX_24070017_IFU_FAULT_EN
               fault_next  = (mem_rresp != 2'b00);
`endif
               state_next  = OUT;
            end
         end
         OUT: begin
            // PC only moves here, so mem_araddr is stable through any AR stall.
            if (out_ready) begin
               pc_next    = dnpc;
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs are pure state decodes: no ready-to-valid paths.
   assign mem_arvalid = (state_reg == REQ);
   assign mem_rready  = (state_reg == RESP);
   assign out_valid   = (state_reg == OUT);
   assign mem_araddr  = pc_reg;
   assign out_pc      = out_pc_reg;

`ifdef YSYX_24070017_IFU_FAULT_EN
   assign out_fault   = fault_reg;
   assign out_inst    = fault_reg ? 32'h00000000 : inst_reg;
`else
   assign out_inst    = inst_reg;
`endif

endmodule

// File: tb/tb_ysyx_24070017_ifu.sv
// tb_ysyx_24070017_ifu -- table-driven bench with a scoreboard for the IFU.
// Define YSYX_24070017_IFU_FAULT_EN to build against the fault-enabled variant.
module tb_ysyx_24070017_ifu;

`ifdef YSYX_24070017_IFU_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_araddr;
   logic        mem_arvalid;
   logic        mem_arready;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_rresp;
   logic        mem_rvalid;
   logic        mem_rready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_fault;
   logic [31:0] dnpc;

   ysyx_24070017_ifu #(.WORD_LENGTH(32), .RESET_PC(32'h80000000)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_araddr  (mem_araddr),
      .mem_arvalid (mem_arvalid),
      .mem_arready (mem_arready),
      .mem_rdata   (mem_rdata),
      .mem_rresp   (mem_rresp),
      .mem_rvalid  (mem_rvalid),
      .mem_rready  (mem_rready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_inst    (out_inst),
      .out_pc      (out_pc),
`ifdef YSYX_24070017_IFU_FAULT_EN
      .out_fault   (out_fault),
`endif
      .dnpc        (dnpc)
   );

`ifndef YSYX_24070017_IFU_FAULT_EN
   assign out_fault = 1'b0;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] pc;
      int          ar_w;
      int          r_w;
      int          o_w;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic [31:0] dnpc;
      logic [31:0] exp_inst;
      logic        exp_fault;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } exp_t;

   vec_t vecs[11];
   exp_t sb[$];
   int   hs_cyc[11];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_arvalid"}, {31'd0, mem_arvalid}, 32'd0);
      chk({tag, "_rready"},  {31'd0, mem_rready},  32'd0);
      chk({tag, "_outvalid"},{31'd0, out_valid},   32'd0);
      chk({tag, "_outinst"}, out_inst,             32'd0);
      chk({tag, "_outpc"},   out_pc,               32'd0);
      chk({tag, "_araddr"},  mem_araddr,           32'h80000000);
      if (FAULT_EN) chk({tag, "_fault"}, {31'd0, out_fault}, 32'd0);
   endtask

   // One full fetch: AR stall, R delay, output backpressure, then handshake.
   task automatic run_vec(input vec_t v, input int idx);
      int          n;
      exp_t        e;
      exp_t        got;
      logic [31:0] hold_inst;
      logic [31:0] hold_pc;
      n = 0;
      while (mem_arvalid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("arvalid", {31'd0, mem_arvalid}, 32'd1);
      chk("araddr", mem_araddr, v.pc);
      repeat (v.ar_w) begin
         @(negedge clk);
         chk("araddr_stall", mem_araddr, v.pc);
         chk("arvalid_stall", {31'd0, mem_arvalid}, 32'd1);
      end
      mem_arready = 1'b1;
      e.pc = v.pc; e.inst = v.exp_inst; e.fault = v.exp_fault;
      sb.push_back(e);
      @(negedge clk);
      mem_arready = 1'b0;
      chk("rready", {31'd0, mem_rready}, 32'd1);
      repeat (v.r_w) begin
         @(negedge clk);
         chk("rready_wait", {31'd0, mem_rready}, 32'd1);
         chk("outvalid_wait", {31'd0, out_valid}, 32'd0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      mem_rresp  = v.rresp;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0BADF00D;
      mem_rresp  = 2'b11;
      chk("outvalid", {31'd0, out_valid}, 32'd1);
      hold_inst = out_inst;
      hold_pc   = out_pc;
      repeat (v.o_w) begin
         @(negedge clk);
         chk("hold_inst", out_inst, hold_inst);
         chk("hold_pc", out_pc, hold_pc);
         chk("hold_noreq", {31'd0, mem_arvalid}, 32'd0);
      end
      out_ready = 1'b1;
      dnpc      = v.dnpc;
      chk("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
         got = sb.pop_front();
         chk("out_pc", out_pc, got.pc);
         chk("out_inst", out_inst, got.inst);
         if (FAULT_EN) chk("out_fault", {31'd0, out_fault}, {31'd0, got.fault});
         $display("[TB] txn %0d pc=%h inst=%h fault=%0b", idx, out_pc, out_inst, out_fault);
      end
      hs_cyc[idx] = cyc;
      @(negedge clk);
      out_ready = 1'b0;
      dnpc      = $urandom;
      chk("next_arvalid", {31'd0, mem_arvalid}, 32'd1);
      chk("next_araddr", mem_araddr, v.dnpc);
   endtask

   initial begin
      logic [31:0] fi;
      fi = FAULT_EN ? 32'h00000000 : 32'hDEADBEEF;
      //          pc            arw r  o  rdata         rresp  dnpc          exp_inst      flt
      vecs[0]  = '{32'h80000000, 0, 0, 0, 32'h00000013, 2'b00, 32'h80000004, 32'h00000013, 1'b0};
      vecs[1]  = '{32'h80000004, 0, 0, 0, 32'h00100093, 2'b00, 32'h80000008, 32'h00100093, 1'b0};
      vecs[2]  = '{32'h80000008, 0, 0, 0, 32'h00200113, 2'b00, 32'h8000000C, 32'h00200113, 1'b0};
      vecs[3]  = '{32'h8000000C, 3, 2, 0, 32'h00100093, 2'b00, 32'h80000010, 32'h00100093, 1'b0};
      vecs[4]  = '{32'h80000010, 0, 0, 5, 32'h00300193, 2'b00, 32'h80000100, 32'h00300193, 1'b0};
      vecs[5]  = '{32'h80000100, 1, 1, 0, 32'hDEADBEEF, 2'b10, 32'h80000104, fi,           FAULT_EN};
      vecs[6]  = '{32'h80000104, 0, 0, 1, 32'h00400213, 2'b00, 32'hFFFFFFFC, 32'h00400213, 1'b0};
      vecs[7]  = '{32'hFFFFFFFC, 0, 0, 0, 32'h00000073, 2'b00, 32'h00000000, 32'h00000073, 1'b0};
      vecs[8]  = '{32'h00000000, 0, 0, 0, 32'h12345678, 2'b00, 32'h80000200, 32'h12345678, 1'b0};
      vecs[9]  = '{32'h80000200, 0, 1, 0, 32'h00500293, 2'b00, 32'h80000300, 32'h00500293, 1'b0};
      vecs[10] = '{32'h80000000, 0, 0, 0, 32'h00100093, 2'b00, 32'h80000004, 32'h00100093, 1'b0};

      rst = 1'b0; mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      mem_rresp = 2'b00; out_ready = 1'b0; dnpc = 32'h0;

      // Reset state, then release: AR request one cycle after first rising edge.
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b1;
      #1;
      chk("release_arvalid_pre", {31'd0, mem_arvalid}, 32'd0);
      @(negedge clk);
      chk("release_arvalid", {31'd0, mem_arvalid}, 32'd1);
      chk("release_araddr", mem_araddr, 32'h80000000);

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Zero-wait stream must sustain at least one instruction every 4 cycles.
      chk("gap_0_1", {31'd0, ((hs_cyc[1] - hs_cyc[0]) <= 4)}, 32'd1);
      chk("gap_1_2", {31'd0, ((hs_cyc[2] - hs_cyc[1]) <= 4)}, 32'd1);

      // Mid-fetch reset: abort in RESP, drop the late response.
      chk("mid_araddr", mem_araddr, 32'h80000300);
      mem_arready = 1'b1;
      @(negedge clk);
      mem_arready = 1'b0;
      chk("mid_rready", {31'd0, mem_rready}, 32'd1);
      rst = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFEF00D;
      mem_rresp  = 2'b00;
      @(negedge clk);
      chk_reset_outputs("midrst_rvalid");
      mem_rvalid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_restart_arvalid", {31'd0, mem_arvalid}, 32'd1);
      chk("mid_restart_araddr", mem_araddr, 32'h80000000);
      chk("mid_restart_inst", out_inst, 32'h00000000);
      run_vec(vecs[10], 10);

      chk("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
